// File: rtl/uart_pattern_sched_pkg.sv
// uart_pattern_sched_pkg
// Shared types and constants for the UART pattern scheduler:
//   state_t  - scheduler FSM states (IDLE, PLAY)
//   PAT_BITS - bits serialised per job
//   IDX_W    - width of the bit index and of requester indices
package uart_pattern_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int PAT_BITS = 8;
    localparam int IDX_W    = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts one position after
// the pointer and wraps, so the last winner has lowest priority next time.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  3      index of the last granted requester
//   grant out N_REQ  one-hot grant (zero when no request)
//   idx   out 3      encoded index of the granted requester (0 when none)
module rr_arbiter
    import uart_pattern_sched_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    int best_d;
    int d;

    // Each requester's distance from the search start; smallest wins.
    always_comb begin
        grant  = '0;
        idx    = '0;
        best_d = N_REQ;
        d      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            d = (i - int'(ptr) - 1 + 2 * N_REQ) % N_REQ;
            if (req[i] && (d < best_d)) begin
                best_d   = d;
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_pattern_sched.sv
// uart_pattern_sched
// Round-robin scheduler in front of a serial bit-pattern generator. Accepts
// 8-bit pattern jobs from N_REQ requesters and plays each granted word onto
// `signal`, one bit per time_eff clock cycles, then pulses `done`.
// Configuration macro: UART_PATTERN_SCHED_MSB_FIRST_EN
//   defined   -> ctrl[7] played first
//   undefined -> ctrl[0] played first (default)
// Ports:
//   clk        in  1         clock
//   reset      in  1         asynchronous active-high reset
//   req_valid  in  N_REQ     job request per requester
//   req_ready  out N_REQ     job accepted this cycle (one-hot or zero)
//   req_ctrl   in  8*N_REQ   pattern words, requester i at [8i+7:8i]
//   req_time   in  TW*N_REQ  bit periods in clk cycles, requester i at [TW*i+TW-1:TW*i]
//   signal     out 1         registered serial pattern output
//   busy       out 1         job playing
//   grant_id   out 3         requester of the job in play / last played
//   done       out 1         one-cycle pulse in the first idle cycle after a job
module uart_pattern_sched
    import uart_pattern_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [8*N_REQ-1:0]    req_ctrl,
    input  logic [TW*N_REQ-1:0]   req_time,
    output logic                  signal,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic                  done
);

    state_t             state, state_n;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   arb_idx;
    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   bit_idx;
    logic [TW-1:0]      cnt;
    logic [7:0]         sel_ctrl, ctrl_q;
    logic [TW-1:0]      sel_time, sel_tm1, tm1_q;
    logic               accept, bit_end, last_bit;

    function automatic logic pat_bit(input logic [7:0] w, input logic [IDX_W-1:0] i);
`ifdef UART_PATTERN_SCHED_MSB_FIRST_EN
        logic [IDX_W-1:0] j;
        j = IDX_W'(PAT_BITS - 1) - i;
        return w[j];
`else
        return w[i];
`endif
    endfunction

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Request selection: pick the winner's ctrl/time words.
    always_comb begin
        sel_ctrl = '0;
        sel_time = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_ctrl = req_ctrl[8*i +: 8];
                sel_time = req_time[TW*i +: TW];
            end
        end
    end

    // A zero period plays as one cycle; subtracting in TW bits after the
    // clamp avoids the wrap to all-ones.
    assign sel_tm1   = (sel_time == '0) ? '0 : sel_time - TW'(1);
    assign req_ready = (state == IDLE) ? arb_grant : '0;
    assign accept    = (state == IDLE) && (|arb_grant);
    assign bit_end   = (cnt == tm1_q);
    assign last_bit  = bit_end && (bit_idx == IDX_W'(PAT_BITS - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)   state_n = PLAY;
            PLAY:    if (last_bit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= IDX_W'(N_REQ - 1);
            bit_idx  <= '0;
            cnt      <= '0;
            signal   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            grant_id <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == PLAY);
            done  <= (state == PLAY) && last_bit;
            if (accept) begin
                rr_ptr   <= arb_idx;
                grant_id <= arb_idx;
                bit_idx  <= '0;
                cnt      <= '0;
                signal   <= pat_bit(sel_ctrl, '0);
            end else if (state == PLAY) begin
                if (bit_end) begin
                    cnt <= '0;
                    if (last_bit) begin
                        signal <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        signal  <= pat_bit(ctrl_q, bit_idx + IDX_W'(1));
                    end
                end else begin
                    cnt <= cnt + TW'(1);
                end
            end
        end
    end

    // Job words latched at accept; only consulted while in PLAY.
    always_ff @(posedge clk) begin
        if (accept) begin
            ctrl_q <= sel_ctrl;
            tm1_q  <= sel_tm1;
        end
    end

endmodule

// File: tb/tb_uart_pattern_sched.sv
module tb_uart_pattern_sched;

    localparam int NR = 3;
    localparam int TW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [8*NR-1:0]   req_ctrl;
    logic [TW*NR-1:0]  req_time;
    logic              signal;
    logic              busy;
    logic [2:0]        grant_id;
    logic              done;

    logic [7:0]        ctrl_a [NR];
    logic [TW-1:0]     time_a [NR];

    int n_assert = 0;
    int n_fail   = 0;
    int rr_ptr;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_ctrl[8*g +: 8]   = ctrl_a[g];
        assign req_time[TW*g +: TW] = time_a[g];
    end

    uart_pattern_sched #(.N_REQ(NR), .TW(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctrl  (req_ctrl),
        .req_time  (req_time),
        .signal    (signal),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first valid requester after the last winner.
    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic exp_bit(input logic [7:0] c, input int b);
`ifdef UART_PATTERN_SCHED_MSB_FIRST_EN
        return c[7 - b];
`else
        return c[b];
`endif
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < NR; i++) begin
            ctrl_a[i] = 8'($urandom);
            time_a[i] = TW'($urandom_range(0, 4));
        end
    endtask

    // Called in an IDLE cycle with requests already driven: the job is
    // accepted at the next edge and expected as an 8*time_eff waveform.
    task automatic play_job(input bit keep, input bit scramble);
        int id, teff;
        logic [7:0] c;
        logic [NR-1:0] exp_rdy;
        #1;
        id = rr_pick(req_valid, rr_ptr);
        if (id < 0) begin
            $display("FAIL play_job no request driven");
            $fatal(1, "bench sequencing error");
        end
        exp_rdy     = '0;
        exp_rdy[id] = 1'b1;
        chk("ready_grant", 32'(req_ready), 32'(exp_rdy));
        c      = ctrl_a[id];
        teff   = (time_a[id] == 0) ? 1 : int'(time_a[id]);
        rr_ptr = id;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < teff; k++) begin
                @(posedge clk); #2;
                if (b == 0 && k == 0) begin
                    if (!keep) req_valid[id] = 1'b0;
                    if (scramble) scramble_inputs();
                    #1;
                end
                chk("signal", 32'(signal), 32'(exp_bit(c, b)));
                chk("busy", 32'(busy), 32'd1);
                chk("done_low", 32'(done), 32'd0);
                chk("grant_id", 32'(grant_id), 32'(id));
                chk("ready_play", 32'(req_ready), 32'd0);
            end
        end
        @(posedge clk); #2;
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("signal_gap", 32'(signal), 32'd0);
        chk("grant_id_end", 32'(grant_id), 32'(id));
    endtask

    initial begin
        logic [7:0] c;
        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            ctrl_a[i] = '0;
            time_a[i] = '0;
        end
        rr_ptr = NR - 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_signal", 32'(signal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #2;
        chk("idle_ready", 32'(req_ready), 32'd0);

        // Single job 0xA5, period 3.
        ctrl_a[0] = 8'hA5; time_a[0] = 3; req_valid = 3'b001;
        play_job(1'b0, 1'b0);

        // Zero period behaves as one cycle.
        ctrl_a[0] = 8'hFF; time_a[0] = 0; req_valid = 3'b001;
        play_job(1'b0, 1'b0);

        // Two persistent requesters alternate, back-to-back.
        ctrl_a[0] = 8'h0F; time_a[0] = 2;
        ctrl_a[1] = 8'hF0; time_a[1] = 2;
        req_valid = 3'b011;
        for (int j = 0; j < 3; j++) play_job(1'b1, 1'b0);
        req_valid = '0;
        @(posedge clk); #2;
        chk("idle_after_alt", 32'(busy), 32'd0);

        // Random jobs; inputs are scrambled while each job plays.
        for (int j = 0; j < 8; j++) begin
            scramble_inputs();
            req_valid = NR'($urandom_range(1, (1 << NR) - 1));
            play_job(1'b0, 1'b1);
        end
        req_valid = '0;
        @(posedge clk); #2;

        // Reset during bit 4 of a job.
        c = 8'($urandom);
        ctrl_a[2] = c; time_a[2] = 2; req_valid = 3'b100;
        repeat (4 * 2 + 1) @(posedge clk);
        #2;
        req_valid = '0;
        chk("pre_reset_bit4", 32'(signal), 32'(exp_bit(c, 4)));
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_signal", 32'(signal), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rr_ptr = NR - 1;
        ctrl_a[0] = 8'h3C; time_a[0] = 1;
        ctrl_a[1] = 8'hC3; time_a[1] = 1;
        req_valid = 3'b011;
        @(posedge clk); #2;
        chk("held_reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        play_job(1'b0, 1'b0);
        play_job(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_pattern_sched.md
# uart_pattern_sched

Arbitrated scheduler in front of the UART bit-pattern generator. Accepts 8-bit pattern jobs (control word plus bit-period word) from `N_REQ` requesters, grants one at a time round-robin, and serialises the granted word onto `signal`, one bit per period. Each job plays exactly once, then `done` pulses. It replaces free-running pattern counters wherever several sources share one serial test/stimulus line.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `TW`, 32, bit-period word width
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  N_REQ  job request per requester
- `req_ready`  out  N_REQ  job accepted this cycle (one-hot or zero)
- `req_ctrl`  in  8*N_REQ  pattern word, requester i at bits [8i+7:8i]
- `req_time`  in  TW*N_REQ  bit period in clk cycles, requester i at [TW*i+TW-1:TW*i]
- `signal`  out  1  serial pattern output, registered
- `busy`  out  1  job playing
- `grant_id`  out  3  index of job in play, or last job played
- `done`  out  1  one-cycle pulse at job completion

## Operation
- FSM states: IDLE, PLAY.
- IDLE: combinational round-robin arbiter over `req_valid`. Search starts at (last granted + 1) mod N_REQ. The winner's `req_ready` is high in the same cycle; all others are low. No valid → all ready low.
- Accept = `req_valid[i] & req_ready[i]` at an edge. On accept:
  - latch ctrl and time_eff = (time==0) ? 1 : time;
  - bit index ← 0, period counter ← 0, `signal` ← ctrl[0];
  - `grant_id` ← i, RR pointer ← i;
  - go to PLAY.
- PLAY: `req_ready` all low. Counter increments each cycle.
  - When counter == time_eff−1: counter ← 0.
  - If bit index < 7: bit index +1, `signal` ← next bit.
  - If bit index == 7: `signal` ← 0, `done` ← 1, go to IDLE.
- Latched ctrl/time are immune to input changes during PLAY.
- Requester holding `req_valid` across PLAY waits; it is not dropped.
- Counter is TW bits. time_eff−1 is computed in TW bits, so no wrap for time=0.
- `busy` = (state == PLAY), registered.

## Timing
- Reset values: `signal`=0, `busy`=0, `done`=0, `grant_id`=0, `req_ready`=0 (combinational from reset state with no valid). State IDLE, RR pointer = N_REQ−1, so requester 0 has first priority.
- Reset mid-PLAY aborts immediately: `signal` 0, no `done`, pointer reset.
- Latency: accept edge k → `signal` = bit0 from cycle k+1. Each bit lasts exactly time_eff cycles. Whole job is 8·time_eff cycles.
- `done` is high in the first IDLE cycle after the job. `req_ready` may be high in that same cycle, so back-to-back jobs have exactly one idle (`signal`=0) cycle between them.
- Simultaneous valids: the RR pointer decides. Two persistent requesters alternate 0,1,0,1.

## Configuration
- `UART_PATTERN_SCHED_MSB_FIRST_EN`:
  - Defined: bit order is ctrl[7] first, ctrl[0] last.
  - Undefined (default): LSB first, ctrl[0] first.
- Timing and `done` are identical in both cases.

## Structure
- Package `uart_pattern_sched_pkg`:
  - state enum (IDLE, PLAY);
  - constant PAT_BITS = 8;
  - bit-index width constant (3).
- Sub-module `rr_arbiter` (`N_REQ` param):
  - inputs: request vector, pointer;
  - outputs: one-hot grant, encoded index.
- Top holds FSM, counters, shift/select logic.

## Test plan
- Single job, req0 ctrl=0xA5, time=3, LSB first → `signal` 1,0,1,0,0,1,0,1, each held 3 cycles from cycle after accept; `done` pulses at cycle 25 after accept; `busy` high 24 cycles.
- time=0, ctrl=0xFF → treated as 1: `signal` high 8 cycles, then 0 with `done`.
- req0 and req1 both valid continuously, ctrl 0x0F/0xF0, time=2 → grants alternate 0,1,0; one idle cycle between jobs; `grant_id` tracks.
- Change `req_ctrl`/`req_time` during PLAY → output unaffected; `req_ready` stays low for a waiting requester until IDLE.
- Assert `reset` at bit 4 of a job → `signal`,`busy`,`done` 0 immediately. After release, req1 and req0 valid → req0 granted first.
- With `UART_PATTERN_SCHED_MSB_FIRST_EN`, ctrl=0x01, time=1 → `signal` 0×7 then 1, then `done`.
